// File: rtl/smoothing_row_ctrl.sv
// -----------------------------------------------------------------------------
// smoothing_row_ctrl
// Row sequencer for the smoothing filter datapath. It feeds exactly ROW_LEN
// samples per row into the filter, flushes the filter pipeline at row end and
// holds the filter in reset for one cycle between rows. A token pipe that
// tracks real samples through the filter re-times the filter output into a
// valid-qualified stream with end-of-row and end-of-frame markers.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle frame start request (honoured only in IDLE)
//   in_valid/in_data  upstream sample stream; in_ready qualifies a transfer
//   filt_reset        active-high filter clear (IDLE and CLEAR)
//   filt_enb          filter enable (RUN transfers and FLUSH cycles)
//   filt_data         filter input (in_data in RUN, zero otherwise)
//   filt_out          filter output
//   out_valid/out_data/out_last  smoothed sample stream, last-of-row marker
//   frame_done        one-cycle pulse after the final output of the frame
//   busy              high whenever the sequencer is not IDLE
//   row_idx           current row, 0-based
// -----------------------------------------------------------------------------
module smoothing_row_ctrl #(
   parameter int DATA_W       = 8,
   parameter int ROW_LEN      = 150,
   parameter int NUM_ROWS     = 4,
   parameter int FILT_LATENCY = 4,
   localparam int CW = $clog2(ROW_LEN + 1),
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int FW = (FILT_LATENCY > 1) ? $clog2(FILT_LATENCY) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              filt_reset,
   output logic              filt_enb,
   output logic [DATA_W-1:0] filt_data,
   input  logic [DATA_W-1:0] filt_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              frame_done,
   output logic              busy,
   output logic [RW-1:0]     row_idx
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_NEXT  = 3'd4
   } state_t;

   state_t                  state_r;
   logic [RW-1:0]           row_idx_r;
   logic [CW-1:0]           smp_cnt_r;
   logic [CW-1:0]           out_cnt_r;
   logic [FW-1:0]           flush_cnt_r;
   logic [FILT_LATENCY-1:0] tok_r;
   logic                    out_valid_r;
   logic [DATA_W-1:0]       out_data_r;
   logic                    out_last_r;
   logic                    frame_done_r;

   logic                    in_ready_s;
   logic                    filt_reset_s;
   logic                    filt_enb_s;
   logic [DATA_W-1:0]       filt_data_s;
   logic                    tok_in_s;
   logic                    xfer_s;
   logic [FILT_LATENCY:0]   tok_ext_s;

   // Filter-side controls decoded from the current state; in RUN the enable
   // and data follow the upstream stream directly so idle cycles never clock
   // a bubble into the filter.
   always_comb begin
      in_ready_s   = 1'b0;
      filt_reset_s = 1'b0;
      filt_enb_s   = 1'b0;
      filt_data_s  = {DATA_W{1'b0}};
      tok_in_s     = 1'b0;
      case (state_r)
         ST_IDLE:  filt_reset_s = 1'b1;
         ST_CLEAR: filt_reset_s = 1'b1;
         ST_RUN: begin
            in_ready_s  = 1'b1;
            filt_enb_s  = in_valid;
            filt_data_s = in_data;
            tok_in_s    = 1'b1;
         end
         ST_FLUSH: filt_enb_s = 1'b1;
         ST_NEXT:  filt_enb_s = 1'b0;
         default:  filt_reset_s = 1'b1;
      endcase
   end

   assign xfer_s    = in_ready_s & in_valid;
   // Shifted token vector: the new token enters bit 0, bit FILT_LATENCY-1 leaves.
   assign tok_ext_s = {tok_r, tok_in_s};

   // Sequencer state, counters, token pipe and registered output stream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         row_idx_r    <= {RW{1'b0}};
         smp_cnt_r    <= {CW{1'b0}};
         out_cnt_r    <= {CW{1'b0}};
         flush_cnt_r  <= {FW{1'b0}};
         tok_r        <= {FILT_LATENCY{1'b0}};
         out_valid_r  <= 1'b0;
         out_data_r   <= {DATA_W{1'b0}};
         out_last_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         out_valid_r  <= 1'b0;
         out_last_r   <= 1'b0;
         frame_done_r <= 1'b0;

         if (filt_enb_s) begin
            tok_r <= tok_ext_s[FILT_LATENCY-1:0];
         end

         // A token leaving the pipe on an enabled edge marks filt_out as the
         // result for a real sample; flushed zeros carry no token.
         if (filt_enb_s && tok_r[FILT_LATENCY-1]) begin
            out_valid_r <= 1'b1;
            out_data_r  <= filt_out;
            out_last_r  <= (out_cnt_r == CW'(ROW_LEN - 1));
            out_cnt_r   <= out_cnt_r + CW'(1);
         end

         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r   <= ST_CLEAR;
                  row_idx_r <= {RW{1'b0}};
               end
            end
            ST_CLEAR: begin
               smp_cnt_r   <= {CW{1'b0}};
               out_cnt_r   <= {CW{1'b0}};
               flush_cnt_r <= {FW{1'b0}};
               tok_r       <= {FILT_LATENCY{1'b0}};
               state_r     <= ST_RUN;
            end
            ST_RUN: begin
               if (xfer_s) begin
                  smp_cnt_r <= smp_cnt_r + CW'(1);
                  if (smp_cnt_r == CW'(ROW_LEN - 1)) begin
                     state_r     <= ST_FLUSH;
                     flush_cnt_r <= {FW{1'b0}};
                  end
               end
            end
            ST_FLUSH: begin
               flush_cnt_r <= flush_cnt_r + FW'(1);
               if (flush_cnt_r == FW'(FILT_LATENCY - 1)) begin
                  state_r <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (row_idx_r == RW'(NUM_ROWS - 1)) begin
                  frame_done_r <= 1'b1;
                  row_idx_r    <= {RW{1'b0}};
                  state_r      <= ST_IDLE;
               end else begin
                  row_idx_r <= row_idx_r + RW'(1);
                  state_r   <= ST_CLEAR;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_s;
   assign filt_reset = filt_reset_s;
   assign filt_enb   = filt_enb_s;
   assign filt_data  = filt_data_s;
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_last   = out_last_r;
   assign frame_done = frame_done_r;
   assign busy       = (state_r != ST_IDLE);
   assign row_idx    = row_idx_r;

endmodule

// File: tb/tb_smoothing_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smoothing_row_ctrl
// Directed bench for smoothing_row_ctrl. Two instances: the default build
// (150 x 4, latency 4) and a tiny build (3 x 1, latency 2). Each drives a
// behavioural filter: an enabled delay line of FILT_LATENCY stages, cleared
// synchronously by filt_reset, so every smoothed sample equals its input.
// -----------------------------------------------------------------------------
module tb_smoothing_row_ctrl;

   localparam int DW = 8;
   localparam int RL = 150;
   localparam int NR = 4;
   localparam int FL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          filt_reset;
   logic          filt_enb;
   logic [DW-1:0] filt_data;
   logic [DW-1:0] filt_out;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          frame_done;
   logic          busy;
   logic [1:0]    row_idx;

   logic          s_start;
   logic          s_in_valid;
   logic [DW-1:0] s_in_data;
   logic          s_in_ready;
   logic          s_filt_reset;
   logic          s_filt_enb;
   logic [DW-1:0] s_filt_data;
   logic [DW-1:0] s_filt_out;
   logic          s_out_valid;
   logic [DW-1:0] s_out_data;
   logic          s_out_last;
   logic          s_frame_done;
   logic          s_busy;
   logic [0:0]    s_row_idx;

   smoothing_row_ctrl #(.DATA_W(DW), .ROW_LEN(RL), .NUM_ROWS(NR), .FILT_LATENCY(FL)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .filt_reset(filt_reset), .filt_enb(filt_enb),
      .filt_data(filt_data), .filt_out(filt_out), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
      .busy(busy), .row_idx(row_idx)
   );

   smoothing_row_ctrl #(.DATA_W(DW), .ROW_LEN(3), .NUM_ROWS(1), .FILT_LATENCY(2)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
      .in_ready(s_in_ready), .filt_reset(s_filt_reset), .filt_enb(s_filt_enb),
      .filt_data(s_filt_data), .filt_out(s_filt_out), .out_valid(s_out_valid),
      .out_data(s_out_data), .out_last(s_out_last), .frame_done(s_frame_done),
      .busy(s_busy), .row_idx(s_row_idx)
   );

   // filter models
   logic [DW-1:0] fp [FL];
   logic [DW-1:0] sfp [2];
   always @(posedge clk) begin
      if (filt_reset) begin
         for (int k = 0; k < FL; k++) fp[k] <= '0;
      end else if (filt_enb) begin
         fp[0] <= filt_data;
         for (int k = 1; k < FL; k++) fp[k] <= fp[k-1];
      end
      if (s_filt_reset) begin
         sfp[0] <= '0;
         sfp[1] <= '0;
      end else if (s_filt_enb) begin
         sfp[0] <= s_filt_data;
         sfp[1] <= sfp[0];
      end
   end
   assign filt_out   = fp[FL-1];
   assign s_filt_out = sfp[1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard / monitor state for the default instance
   int exp_q[$];
   int n_out, n_last, n_fd, n_clear;
   int last_cyc, fd_cyc;
   int xfers_before;
   int e;

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = -1;
         check_val("out_data", {24'd0, out_data}, e);
         n_out++;
         check_val("out_last", {31'd0, out_last}, {31'd0, (n_out % RL) == 0});
         if (out_last) begin
            n_last++;
            last_cyc = cyc;
         end
      end
      if (frame_done) begin
         n_fd++;
         fd_cyc = cyc;
      end
      if (busy && filt_reset) n_clear++;
      if (in_ready) begin
         check_val("filt_enb_mirror", {31'd0, filt_enb}, {31'd0, in_valid});
         check_val("filt_data_pass", {24'd0, filt_data}, {24'd0, in_data});
         check_val("row_idx_run", {30'd0, row_idx}, xfers_before / RL);
      end
   end

   // monitor for the small instance
   int s_n_out = 0, s_n_fd = 0, s_last_at = 0, s_last_cyc = 0, s_fd_cyc = 0;
   int s_vals [3];
   always @(negedge clk) begin
      if (s_out_valid) begin
         if (s_n_out < 3) s_vals[s_n_out] = int'(s_out_data);
         s_n_out++;
         if (s_out_last) begin
            s_last_at  = s_n_out;
            s_last_cyc = cyc;
         end
      end
      if (s_frame_done) begin
         s_n_fd++;
         s_fd_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer n samples; a transfer happens on the next edge when in_ready is high.
   task automatic stream(input int n, input bit const100, input bit toggle, input int start_at);
      int  i     = 0;
      int  guard = 0;
      bit  ph    = 1'b1;
      while (i < n && guard < 4000) begin
         xfers_before = i;
         in_valid = toggle ? ph : 1'b1;
         ph       = ~ph;
         in_data  = const100 ? 8'd100 : 8'(i % RL);
         start    = (i == start_at);
         if (in_valid && in_ready) begin
            exp_q.push_back(int'(in_data));
            i++;
         end
         tick();
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check_val("stream_complete", i, n);
   endtask

   task automatic wait_done();
      int k = 0;
      while (n_fd == 0 && k < 200) begin
         tick();
         k++;
      end
      check_val("frame_done_seen", {31'd0, n_fd != 0}, 32'd1);
      repeat (3) tick();
   endtask

   task automatic run_frame(input bit const100, input bit toggle);
      n_out = 0; n_last = 0; n_fd = 0; n_clear = 0;
      exp_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      stream(RL * NR, const100, toggle, 200);
      // now in FLUSH of the last row: a start here must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check_val("n_out", n_out, RL * NR);
      check_val("n_last", n_last, NR);
      check_val("n_frame_done", n_fd, 1);
      check_val("clear_cycles", n_clear, NR);
      check_val("fd_after_last", {31'd0, fd_cyc > last_cyc}, 32'd1);
      check_val("busy_end", {31'd0, busy}, 32'd0);
      check_val("row_idx_end", {30'd0, row_idx}, 32'd0);
      check_val("scoreboard_empty", exp_q.size(), 0);
   endtask

   int snap;
   int guard;

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
      xfers_before = 0;
      #12;
      check_val("rst_in_ready",   {31'd0, in_ready},   32'd0);
      check_val("rst_filt_enb",   {31'd0, filt_enb},   32'd0);
      check_val("rst_out_valid",  {31'd0, out_valid},  32'd0);
      check_val("rst_out_last",   {31'd0, out_last},   32'd0);
      check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check_val("rst_busy",       {31'd0, busy},       32'd0);
      check_val("rst_filt_data",  {24'd0, filt_data},  32'd0);
      check_val("rst_out_data",   {24'd0, out_data},   32'd0);
      check_val("rst_filt_reset", {31'd0, filt_reset}, 32'd1);
      check_val("rst_row_idx",    {30'd0, row_idx},    32'd0);
      // start while reset is low must not be taken
      start = 1'b1;
      tick();
      check_val("start_in_reset", {31'd0, busy}, 32'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();

      // ramp 0..149 per row, valid always high
      run_frame(1'b0, 1'b0);
      // constant 100 input
      run_frame(1'b1, 1'b0);
      // in_valid toggling every cycle
      run_frame(1'b0, 1'b1);

      // reset at sample 75 of row 2
      n_out = 0; n_last = 0; n_fd = 0; n_clear = 0;
      exp_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      stream(2 * RL + 75, 1'b0, 1'b0, -1);
      check_val("abort_row_idx_before", {30'd0, row_idx}, 32'd2);
      reset = 1'b0;
      #1;
      check_val("abort_busy",       {31'd0, busy},       32'd0);
      check_val("abort_in_ready",   {31'd0, in_ready},   32'd0);
      check_val("abort_out_valid",  {31'd0, out_valid},  32'd0);
      check_val("abort_filt_enb",   {31'd0, filt_enb},   32'd0);
      check_val("abort_filt_reset", {31'd0, filt_reset}, 32'd1);
      check_val("abort_row_idx",    {30'd0, row_idx},    32'd0);
      check_val("abort_out_data",   {24'd0, out_data},   32'd0);
      exp_q.delete();
      snap = n_out;
      tick();
      reset = 1'b1;
      repeat (40) tick();
      check_val("abort_no_frame_done", n_fd, 0);
      check_val("abort_no_more_out", n_out, snap);
      check_val("abort_idle", {31'd0, busy}, 32'd0);

      // fresh frame after the abort
      run_frame(1'b0, 1'b0);

      // small instance: ROW_LEN 3, NUM_ROWS 1, FILT_LATENCY 2
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      snap  = 0;
      guard = 0;
      while (snap < 3 && guard < 50) begin
         s_in_valid = 1'b1;
         s_in_data  = 8'(7 + snap);
         if (s_in_ready) snap++;
         tick();
         guard++;
      end
      s_in_valid = 1'b0;
      guard = 0;
      while (s_n_fd == 0 && guard < 50) begin
         tick();
         guard++;
      end
      repeat (2) tick();
      check_val("s_n_out", s_n_out, 3);
      check_val("s_val0", s_vals[0], 7);
      check_val("s_val1", s_vals[1], 8);
      check_val("s_val2", s_vals[2], 9);
      check_val("s_last_on_third", s_last_at, 3);
      check_val("s_n_frame_done", s_n_fd, 1);
      check_val("s_fd_delay", s_fd_cyc - s_last_cyc, 1);
      check_val("s_busy_end", {31'd0, s_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/smoothing_row_ctrl.md
Name: smoothing_row_ctrl

Overview:
Row sequencer for the smoothing filter datapath. Accepts a pixel stream, feeds exactly ROW_LEN samples per row into the filter, flushes the filter pipeline at row end and pulses the filter's reset between rows. Re-times filter output into a valid-qualified stream with end-of-row and end-of-frame markers. Sits between the sample source (file reader / upstream buffer) and the edge-detection stages.

Parameters:
DATA_W, 8, sample width (filter In_Arrary / SmoothedArray width)
ROW_LEN, 150, samples per row
NUM_ROWS, 4, rows per frame
FILT_LATENCY, 4, filter latency in enabled cycles (input sample to matching output)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
in_valid  in  1  upstream sample valid
in_data  in  DATA_W  upstream sample
in_ready  out  1  block accepts in_data this cycle (in_valid & in_ready = transfer)
filt_reset  out  1  active-high reset to smoothing filter
filt_enb  out  1  filter enable
filt_data  out  DATA_W  filter input
filt_out  in  DATA_W  filter output
out_valid  out  1  smoothed sample valid (one-cycle pulse per sample)
out_data  out  DATA_W  smoothed sample
out_last  out  1  with out_valid: last sample of row
frame_done  out  1  one-cycle pulse after last output of last row
busy  out  1  high in any state except IDLE
row_idx  out  clog2(NUM_ROWS)  current row, 0-based

Behaviour:
- Reset (reset low, async): state IDLE; counters, token pipe, row_idx = 0; in_ready, filt_enb, out_valid, out_last, frame_done, busy = 0; filt_data, out_data = 0; filt_reset = 1 (filter held clear throughout reset).
- FSM states: IDLE, CLEAR, RUN, FLUSH, NEXT.
- IDLE: filt_reset = 1. start -> CLEAR, row_idx = 0. start in any other state ignored.
- CLEAR: exactly one cycle, filt_reset = 1, filt_enb = 0, sample count = 0 -> RUN.
- RUN: filt_reset = 0, in_ready = 1. filt_enb = in_valid; filt_data = in_data (combinational pass-through). Each transfer increments sample count. Transfer with count == ROW_LEN-1 -> FLUSH. in_valid low: filt_enb = 0, filter and token pipe frozen (no bubbles enter the filter).
- FLUSH: in_ready = 0, filt_enb = 1, filt_data = 0, for exactly FILT_LATENCY cycles -> NEXT.
- NEXT: one cycle. row_idx == NUM_ROWS-1 -> frame_done = 1 next cycle, row_idx = 0, -> IDLE; else row_idx + 1 -> CLEAR.
- Token pipe: FILT_LATENCY-bit shift register advancing only on filt_enb cycles; shifts in 1 for RUN transfers, 0 for FLUSH cycles; cleared in CLEAR/reset. On an edge where filt_enb = 1 and the bit leaving the pipe is 1: register out_data <= filt_out, out_valid <= 1 next cycle; otherwise out_valid <= 0.
- Exactly ROW_LEN out_valid pulses per row, in input order; out_last asserted with the ROW_LEN-th one (output counter, reset in CLEAR). Flushed zeros never produce out_valid.
- frame_done pulses after the out_last of row NUM_ROWS-1 has been emitted (frame_done cycle >= out_last cycle + 1).
- No output backpressure: downstream must accept every out_valid.
- Sample/output counters width clog2(ROW_LEN+1); no wrap within a row.
- Reset low mid-row: immediate return to IDLE, partial row discarded, no out_valid/out_last/frame_done generated for it.
- start coincident with reset deassertion: accepted only on a clock edge with reset high.

Test Plan:
- Default params, start, stream 600 samples 0..149 repeated with in_valid always 1 -> 600 out_valid, out_last at outputs 150/300/450/600, filt_reset high exactly 1 cycle between rows, one frame_done pulse, then busy = 0.
- Constant input 100 for a full row -> every out_data = 100 (filter steady-state check), no out_valid during FLUSH.
- in_valid toggling 1/0 every cycle in RUN -> filt_enb mirrors in_valid, still exactly 150 outputs per row in order, row completes in ~300 RUN cycles.
- start pulsed during RUN and FLUSH -> ignored; row_idx and counts unaffected.
- reset low for 1 cycle at sample 75 of row 2 -> all outputs 0 and state IDLE immediately; no frame_done; fresh start yields correct frame from row 0.
- ROW_LEN = 3, NUM_ROWS = 1, FILT_LATENCY = 2 -> 3 outputs, out_last on third, frame_done one cycle later.
